// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: ALUCtrl op codes, sequencer
// state encoding and small op-classification helpers.
package alu_pkg;

  // ALUCtrl encodings as issued by the control unit
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SLTFIX = 2'd2,
    ST_DONE   = 2'd3
  } alu_state_e;

  // True for the six supported op codes
  function automatic logic is_valid_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
  endfunction

  // True for ops whose signed overflow is reported
  function automatic logic is_addsub(input logic [3:0] op);
    return op inside {ALU_ADD, ALU_SUB};
  endfunction

  // True for pure bitwise ops
  function automatic logic is_logic_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_NOR};
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice. Operands are optionally inverted, then
// op selects AND (00), OR (01), sum (10). Op 11 (SLT) also passes the sum;
// the sequencer replaces the word result once the MSB has been seen.
module alu_bit_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       i_a_inv,
  input  logic       i_b_inv,
  input  logic [1:0] i_op,
  output logic       o_res,
  output logic       o_cout
);

  logic w_a;
  logic w_b;
  logic w_sum;

  assign w_a    = i_a ^ i_a_inv;
  assign w_b    = i_b ^ i_b_inv;
  assign w_sum  = w_a ^ w_b ^ i_cin;
  assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));

  // Result select for this bit
  always_comb begin
    o_res = 1'b0;
    case (i_op)
      2'b00:   o_res = w_a & w_b;
      2'b01:   o_res = w_a | w_b;
      default: o_res = w_sum;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: latches operands on start, runs one alu_bit_slice
// over WIDTH cycles LSB first, resolves SLT from the MSB sum and overflow,
// and presents result/zero/overflow with a one-cycle done pulse.
// Optional build macro ALU_FAST_LOGIC_EN: AND/OR/NOR are computed word-wide
// at accept and skip the serial run (done in the following cycle).
module alu_bitserial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sh;
  logic             r_carry;
  logic             r_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic             w_accept;
  logic             w_fast_accept;
  logic             w_last;
  logic             w_bit_res;
  logic             w_bit_cout;
  logic             w_msb_ovf;
  logic [WIDTH-1:0] w_sh_next;

  assign w_accept  = (r_state == ST_IDLE) && start_i;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_msb_ovf = r_carry ^ w_bit_cout;
  // Bits collected so far plus the bit produced this cycle, LSB-aligned once
  // the MSB cycle is reached.
  assign w_sh_next = {w_bit_res, r_sh};

`ifdef ALU_FAST_LOGIC_EN
  logic [WIDTH-1:0] w_fast_result;

  assign w_fast_accept = is_logic_op(ctrl_i);

  // Word-wide bitwise result for the bypass path
  always_comb begin
    w_fast_result = '0;
    case (ctrl_i)
      ALU_AND: w_fast_result = src1_i & src2_i;
      ALU_OR:  w_fast_result = src1_i | src2_i;
      ALU_NOR: w_fast_result = ~(src1_i | src2_i);
      default: w_fast_result = '0;
    endcase
  end
`else
  assign w_fast_accept = 1'b0;
`endif

  alu_bit_slice u_slice (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_cin   (r_carry),
    .i_a_inv (r_ctrl[3]),
    .i_b_inv (r_ctrl[2]),
    .i_op    (r_ctrl[1:0]),
    .o_res   (w_bit_res),
    .o_cout  (w_bit_cout)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start_i) w_next_state = w_fast_accept ? ST_DONE : ST_RUN;
      ST_RUN:    if (w_last)  w_next_state = (r_ctrl == ALU_SLT) ? ST_SLTFIX : ST_DONE;
      ST_SLTFIX: w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_o = (r_state != ST_IDLE);
    done_o = (r_state == ST_DONE);
  end

  // Operand latch, serial datapath and result/flag capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_ctrl     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sh       <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_ctrl  <= ctrl_i;
      r_a     <= src1_i;
      r_b     <= src2_i;
      r_carry <= (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT);
      r_ovf   <= 1'b0;
`ifdef ALU_FAST_LOGIC_EN
      if (w_fast_accept) begin
        r_result   <= w_fast_result;
        r_overflow <= 1'b0;
      end
`endif
    end else if (r_state == ST_RUN) begin
      r_cnt   <= r_cnt + 1'b1;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sh    <= w_sh_next[WIDTH-1:1];
      r_carry <= w_bit_cout;
      if (w_last) begin
        r_ovf <= w_msb_ovf;
        // SLT defers its result write to SLTFIX, where MSB sum and overflow are both stable
        if (r_ctrl != ALU_SLT) begin
          r_result   <= is_valid_op(r_ctrl) ? w_sh_next : '0;
          r_overflow <= is_addsub(r_ctrl) & w_msb_ovf;
        end
      end
    end else if (r_state == ST_SLTFIX) begin
      r_result   <= {{(WIDTH-1){1'b0}}, r_sh[WIDTH-2] ^ r_ovf};
      r_overflow <= 1'b0;
    end
  end

  assign result_o   = r_result;
  assign zero_o     = (r_result == '0);
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq (WIDTH=32). Honours
// ALU_FAST_LOGIC_EN when defined for the bitwise-op latency.
module tb_alu_bitserial_seq;

  localparam int W = 32;
`ifdef ALU_FAST_LOGIC_EN
  localparam int NOR_LAT = 1;
`else
  localparam int NOR_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ctrl = 4'd0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .zero_o     (zero),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on whole words
  task automatic ref_model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic ov, output int lat);
    r   = '0;
    ov  = 1'b0;
    lat = W + 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'b0110: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'b0111: begin r = ($signed(a) < $signed(b)) ? W'(1) : W'(0); lat = W + 2; end
      4'b1100: r = ~(a | b);
      default: ;
    endcase
`ifdef ALU_FAST_LOGIC_EN
    if (c == 4'b0000 || c == 4'b0001 || c == 4'b1100) lat = 1;
`endif
  endtask

  // Issue one op and wait (bounded) for done; returns at the done cycle, lat=-1 on timeout
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat     = -1;
    @(negedge clk);
    if (busy !== 1'b0) busy_ok = 1'b0;
    start = 1'b1; ctrl = c; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; ctrl = 4'($urandom); src1 = $urandom; src2 = $urandom;
    for (int i = 1; i <= W + 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset done got %b exp 0", done); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset result got %h exp 0", result); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("FAIL reset zero got %b exp 1", zero); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset ovf got %b exp 0", ovf); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]   dc [5] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100};
    logic [W-1:0] da [5] = '{32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFD, 32'h80000000, 32'hF0F0F0F0};
    logic [W-1:0] db [5] = '{32'h00000001, 32'h00000005, 32'h00000002, 32'h00000001, 32'h0F0F0000};
    logic [W-1:0] dr [5] = '{32'h80000000, 32'h00000000, 32'h00000001, 32'h00000001, 32'h00000F0F};
    logic         dov[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int           dl [5] = '{W + 1, W + 1, W + 2, W + 2, NOR_LAT};
    int lat;
    bit bok;
    for (int k = 0; k < 5; k++) begin
      do_op(dc[k], da[k], db[k], lat, bok);
      n_checks++; if (lat != dl[k]) $display("FAIL dir[%0d] latency got %0d exp %0d", k, lat, dl[k]); else n_pass++;
      n_checks++; if (!bok) $display("FAIL dir[%0d] busy window got gap exp continuous", k); else n_pass++;
      n_checks++; if (result !== dr[k]) $display("FAIL dir[%0d] result got %h exp %h", k, result, dr[k]); else n_pass++;
      n_checks++; if (zero !== (dr[k] == '0)) $display("FAIL dir[%0d] zero got %b exp %b", k, zero, dr[k] == '0); else n_pass++;
      n_checks++; if (ovf !== dov[k]) $display("FAIL dir[%0d] ovf got %b exp %b", k, ovf, dov[k]); else n_pass++;
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL dir[%0d] post-done got done=%b busy=%b exp 0/0", k, done, busy); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [3:0]   ops [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                               4'b0011, 4'b0100, 4'b1000, 4'b1111, 4'b0101};
    logic [W-1:0] edges [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    logic [3:0]   c;
    logic [W-1:0] a, b, er;
    logic         eo;
    int el, lat;
    bit bok;
    for (int k = 0; k < 24; k++) begin
      c = ops[$urandom_range(0, 10)];
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      ref_model(c, a, b, er, eo, el);
      do_op(c, a, b, lat, bok);
      n_checks++; if (lat != el) $display("FAIL rnd[%0d] op=%b latency got %0d exp %0d", k, c, lat, el); else n_pass++;
      n_checks++; if (!bok) $display("FAIL rnd[%0d] op=%b busy window got gap exp continuous", k, c); else n_pass++;
      n_checks++; if (result !== er) $display("FAIL rnd[%0d] op=%b a=%h b=%h result got %h exp %h", k, c, a, b, result, er); else n_pass++;
      n_checks++; if (zero !== (er == '0)) $display("FAIL rnd[%0d] zero got %b exp %b", k, zero, er == '0); else n_pass++;
      n_checks++; if (ovf !== eo) $display("FAIL rnd[%0d] op=%b a=%h b=%h ovf got %b exp %b", k, c, a, b, ovf, eo); else n_pass++;
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL rnd[%0d] done width got %b exp 0", k, done); else n_pass++;
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] a = 32'h12345678, b = 32'h0F0F0F0F, er, r1, r2;
    logic         eo;
    int el, dones = 0, first_done = -1, bad_busy = 0, second = -1;
    ref_model(4'b0010, a, b, er, eo, el);
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0010; src1 = a; src2 = b;
    r1 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy !== ((c <= W + 1) || (c >= W + 3))) bad_busy++;
      if (done === 1'b1) begin
        dones++;
        if (first_done < 0) begin first_done = c; r1 = result; end
      end
    end
    start = 1'b0;
    n_checks++; if (dones != 1) $display("FAIL held done count got %0d exp 1", dones); else n_pass++;
    n_checks++; if (first_done != W + 1) $display("FAIL held latency got %0d exp %0d", first_done, W + 1); else n_pass++;
    n_checks++; if (bad_busy != 0) $display("FAIL held busy pattern got %0d bad cycles exp 0", bad_busy); else n_pass++;
    n_checks++; if (r1 !== er) $display("FAIL held result got %h exp %h", r1, er); else n_pass++;
    r2 = '0;
    for (int c = 41; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin second = c; r2 = result; break; end
    end
    n_checks++; if (second != 2 * (W + 1) + 1) $display("FAIL held second done cycle got %0d exp %0d", second, 2 * (W + 1) + 1); else n_pass++;
    n_checks++; if (r2 !== er) $display("FAIL held second result got %h exp %h", r2, er); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a = 32'h00001000, b = 32'h00002001, er;
    logic         eo;
    int el, lat = -1;
    ref_model(4'b0110, a, b, er, eo, el);
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0110; src1 = a; src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= W + 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = c; break; end
      if (c == 5) begin start = 1'b1; ctrl = 4'b0010; src1 = $urandom; src2 = $urandom; end
      else start = 1'b0;
    end
    n_checks++; if (lat != W + 1) $display("FAIL b2b latency got %0d exp %0d", lat, W + 1); else n_pass++;
    n_checks++; if (result !== er) $display("FAIL b2b result got %h exp %h", result, er); else n_pass++;
    n_checks++; if (ovf !== eo) $display("FAIL b2b ovf got %b exp %b", ovf, eo); else n_pass++;
    // start in the done cycle must be dropped
    start = 1'b1; ctrl = 4'b0001; src1 = $urandom; src2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b idle after done got busy=%b exp 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result !== er) $display("FAIL b2b done-cycle start got busy=%b result=%h exp 0/%h", busy, result, er); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b, er;
    logic         eo;
    int el, lat, dones = 0;
    bit bok;
    do_op(4'b0010, 32'd1, 32'd2, lat, bok);
    n_checks++; if (result !== 32'd3) $display("FAIL rstmid pre result got %h exp 3", result); else n_pass++;
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0010; src1 = 32'hDEADBEEF; src2 = 32'h01010101;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL rstmid result got %h exp 0", result); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("FAIL rstmid zero got %b exp 1", zero); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) $display("FAIL rstmid stray done got %0d exp 0", dones); else n_pass++;
    a = $urandom; b = $urandom;
    ref_model(4'b0010, a, b, er, eo, el);
    do_op(4'b0010, a, b, lat, bok);
    n_checks++; if (lat != el) $display("FAIL rstmid new latency got %0d exp %0d", lat, el); else n_pass++;
    n_checks++; if (result !== er || ovf !== eo) $display("FAIL rstmid new result got %h/%b exp %h/%b", result, ovf, er, eo); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
